// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, field layouts, load-op encodings.
package cpu_defs;

  localparam int ES_BUS_W  = 75;
  localparam int MS_BUS_W  = 70;
  localparam int FWD_BUS_W = 39;

  // Field offsets of es_to_ms_bus (LSB positions)
  localparam int ES_PC_LSB      = 43;
  localparam int ES_GR_WE_BIT   = 42;
  localparam int ES_DEST_LSB    = 37;
  localparam int ES_ALU_LSB     = 5;
  localparam int ES_MEM_REQ_BIT = 4;
  localparam int ES_RES_MEM_BIT = 3;
  localparam int ES_LOAD_OP_LSB = 0;

  // Field offsets of ms_to_ws_bus
  localparam int MS_PC_LSB    = 38;
  localparam int MS_GR_WE_BIT = 37;
  localparam int MS_DEST_LSB  = 32;
  localparam int MS_RES_LSB   = 0;

  // Field offsets of ms_to_ds_bus
  localparam int DS_PENDING_BIT = 38;
  localparam int DS_RF_WE_BIT   = 37;
  localparam int DS_DEST_LSB    = 32;
  localparam int DS_RES_LSB     = 0;

  // Load-op encodings; unlisted codes (5..7) behave like LW
  typedef enum logic [2:0] {
    LOAD_LW  = 3'd0,
    LOAD_LB  = 3'd1,
    LOAD_LBU = 3'd2,
    LOAD_LH  = 3'd3,
    LOAD_LHU = 3'd4
  } load_op_e;

  // Response tracking state, derived from ms_valid / mem_req / buf_valid
  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_WAIT = 2'd1,
    RESP_HELD = 2'd2
  } resp_state_e;

  // Instruction as handed over by EX (75 bits, MSB first)
  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic        mem_req;
    logic        res_from_mem;
    logic [2:0]  load_op;
  } es_to_ms_t;

  // Instruction as handed to WB (70 bits)
  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
  } ms_to_ws_t;

  // Forwarding / hazard information for ID (39 bits)
  typedef struct packed {
    logic        res_pending;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
  } ms_to_ds_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword and sign/zero-extends it.
module mem_load_align
  import cpu_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  load_op,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed sub-word, then extend according to the load type
  always_comb begin
    byte_sel  = rdata[{off, 3'b000} +: 8];
    // Halfword loads use only off[1]; off[0] is ignored
    half_sel  = off[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (load_op)
      LOAD_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: load_data = {24'd0, byte_sel};
      LOAD_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: load_data = {16'd0, half_sel};
      default:  load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EX instruction, waits for the data-SRAM response,
// aligns load data and drives the WB bus and the ID forwarding bus.
//
// Handshake: a stage-to-stage transfer happens on a rising edge where the
// producer's valid and the consumer's allowin are both 1. valid never depends
// on allowin from the same consumer; allowin may depend on the producer state.
module mem_stage
  import cpu_defs::*;
#(
  parameter int ES_BUS_W  = cpu_defs::ES_BUS_W,
  parameter int MS_BUS_W  = cpu_defs::MS_BUS_W,
  parameter int FWD_BUS_W = cpu_defs::FWD_BUS_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 es_to_ms_valid,
  input  logic [ES_BUS_W-1:0]  es_to_ms_bus,
  output logic                 ms_allowin,
  input  logic                 ws_allowin,
  output logic                 ms_to_ws_valid,
  output logic [MS_BUS_W-1:0]  ms_to_ws_bus,
  output logic [FWD_BUS_W-1:0] ms_to_ds_bus,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata
);

  es_to_ms_t   es_in;
  es_to_ms_t   ms_inst_q, ms_inst_d;
  logic        ms_valid_q, ms_valid_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;

  logic        ms_ready_go;
  logic        ms_xfer;
  resp_state_e resp_state;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic [31:0] final_result;
  ms_to_ws_t   ws_out;
  ms_to_ds_t   ds_out;

  assign es_in = es_to_ms_bus;

  // Handshake: a memory instruction may go once its response arrives or is buffered
  always_comb begin
    ms_ready_go    = !ms_inst_q.mem_req || data_sram_data_ok || buf_valid_q;
    ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    ms_to_ws_valid = ms_valid_q && ms_ready_go;
    ms_xfer        = ms_to_ws_valid && ws_allowin;
  end

  // Response state as seen by the data-SRAM side
  always_comb begin
    if (buf_valid_q) begin
      resp_state = RESP_HELD;
    end else if (ms_valid_q && ms_inst_q.mem_req) begin
      resp_state = RESP_WAIT;
    end else begin
      resp_state = RESP_IDLE;
    end
  end

  // Next instruction: refill whenever MEM can accept; bus only latched when EX is valid
  always_comb begin
    ms_valid_d = ms_valid_q;
    ms_inst_d  = ms_inst_q;
    if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
      if (es_to_ms_valid) begin
        ms_inst_d = es_in;
      end
    end
  end

  // Response buffer: capture read data only when WB stalls on the data_ok cycle
  always_comb begin
    buf_valid_d = buf_valid_q;
    rdata_buf_d = rdata_buf_q;
    case (resp_state)
      RESP_WAIT: begin
        if (data_sram_data_ok && !ws_allowin) begin
          buf_valid_d = 1'b1;
          rdata_buf_d = data_sram_rdata;
        end
      end
      RESP_HELD: begin
        // buf_valid implies ms_valid, so ws_allowin here means the transfer edge
        if (ms_xfer) begin
          buf_valid_d = 1'b0;
        end
      end
      default: begin
        // data_ok outside WAIT carries no owner and is dropped
      end
    endcase
  end

  // Stage state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      ms_inst_q   <= '0;
      buf_valid_q <= 1'b0;
      rdata_buf_q <= 32'd0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      ms_inst_q   <= ms_inst_d;
      buf_valid_q <= buf_valid_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  // Buffered data wins; otherwise read data passes straight through
  always_comb begin
    mem_rdata = buf_valid_q ? rdata_buf_q : data_sram_rdata;
  end

  mem_load_align u_load_align (
    .rdata     (mem_rdata),
    .off       (ms_inst_q.alu_result[1:0]),
    .load_op   (ms_inst_q.load_op),
    .load_data (load_data)
  );

  // Result selection and output bus assembly
  always_comb begin
    final_result        = ms_inst_q.res_from_mem ? load_data : ms_inst_q.alu_result;

    ws_out.pc           = ms_inst_q.pc;
    ws_out.gr_we        = ms_inst_q.gr_we;
    ws_out.dest         = ms_inst_q.dest;
    ws_out.final_result = final_result;

    // ID must stall on a dest match while the load value is not yet known
    ds_out.res_pending  = ms_valid_q && ms_inst_q.res_from_mem && !ms_ready_go;
    ds_out.rf_we        = ms_valid_q && ms_inst_q.gr_we;
    ds_out.dest         = ms_valid_q ? ms_inst_q.dest : 5'd0;
    ds_out.final_result = ms_valid_q ? final_result : 32'd0;
  end

  assign ms_to_ws_bus = ws_out;
  assign ms_to_ds_bus = ds_out;

endmodule
